// File: rtl/gated_pipe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gated_pipe_rr_arbiter
// Purpose  : Round-robin arbiter feeding a shared two-stage gated pipeline
//            with run/drain sequencing and valid/ready output backpressure.
//            Optional macro GPA_DROP_GATED_EN drops gated transactions and
//            counts them on drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module gated_pipe_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]  req_gate,
    output logic [NREQ-1:0]  gnt,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [IDW-1:0]   out_id,
    input  logic             out_ready,
    output logic             busy
`ifdef GPA_DROP_GATED_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic             r_v1;
    logic             r_v2;
    logic             r_g1;
    logic [DW-1:0]    r_d1;
    logic [DW-1:0]    r_d2;
    logic [IDW-1:0]   r_id1;
    logic [IDW-1:0]   r_id2;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_found;
    logic             w_grant;
    logic             w_keep;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW:0]     w_scan;
    logic [DW-1:0]    w_win_data;
    logic             w_win_gate;

    assign w_adv2 = !r_v2 | out_ready;
    assign w_adv1 = !r_v1 | w_adv2;

    // Rotating priority scan starting at r_ptr; one extra bit handles the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NREQ)) begin
                w_scan = w_scan - (IDW+1)'(NREQ);
            end
            if (!w_found && req[w_scan[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        w_win_gate = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_data = req_data[i*DW +: DW];
                w_win_gate = req_gate[i];
            end
        end
    end

    assign w_grant   = !rst && (r_state == S_RUN) && enable && !flush && w_adv1 && w_found;
    assign gnt       = w_grant ? (NREQ'(1) << w_win) : '0;
    assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && !flush) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush || !enable) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_v1 && !r_v2) w_state_nxt = (enable && !flush) ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef GPA_DROP_GATED_EN
    assign w_keep = r_g1;
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_g1    <= 1'b0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_id1   <= '0;
            r_id2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
                r_v1  <= 1'b1;
                r_d1  <= w_win_data;
                r_g1  <= w_win_gate;
                r_id1 <= w_win;
            end else if (w_adv2) begin
                r_v1  <= 1'b0;
            end
            if (w_adv2) begin
                r_v2  <= r_v1 & w_keep;
                r_d2  <= r_d1 & {DW{r_g1}};
                r_id2 <= r_id1;
            end
        end
    end

`ifdef GPA_DROP_GATED_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_adv2 && r_v1 && !r_g1 && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_valid = r_v2;
    assign out_data  = r_d2;
    assign out_id    = r_id2;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gated_pipe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gated_pipe_rr_arbiter
// Purpose  : Scoreboard bench for gated_pipe_rr_arbiter with a queue-based
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gated_pipe_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b1;
    logic               flush = 1'b0;
    logic               out_ready = 1'b1;
    logic [NREQ-1:0]    req = '1;
    logic [NREQ-1:0]    req_gate = '1;
    logic [NREQ*DW-1:0] req_data = 32'h44332211;
    logic [NREQ-1:0]    gnt;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [IDW-1:0]     out_id;
    logic               busy;
`ifdef GPA_DROP_GATED_EN
    logic [15:0]        drop_cnt;
    int                 m_drops = 0;
`endif

    gated_pipe_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .req(req), .req_data(req_data), .req_gate(req_gate), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy)
`ifdef GPA_DROP_GATED_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // pos: 1 = waiting in the first stage, 2 = presented at the output
    typedef struct {
        logic [DW-1:0] data;
        int            id;
        bit            gate;
        int            pos;
    } txn_t;

    txn_t pipe[$];
    txn_t sb[$];
    int   m_mode = 0;   // 0 idle, 1 run, 2 drain
    int   m_ptr  = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_on = 1'b0;

    function automatic int winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit grant_ok();
        return !rst && (m_mode == 1) && enable && !flush &&
               ((pipe.size() < 2) || out_ready) && (winner() >= 0);
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        return grant_ok() ? (NREQ'(1) << winner()) : '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances at each rising edge from pre-edge inputs.
    always @(posedge clk) begin
        bit   g;
        int   w;
        bit   empty0;
        txn_t t;
        if (rst) begin
            pipe.delete();
            sb.delete();
            m_mode = 0;
            m_ptr  = 0;
            mon_on = 1'b1;
`ifdef GPA_DROP_GATED_EN
            m_drops = 0;
`endif
        end else begin
            g      = grant_ok();
            w      = winner();
            empty0 = (pipe.size() == 0);
            case (m_mode)
                0: if (enable && !flush) m_mode = 1;
                1: if (flush || !enable) m_mode = 2;
                default: if (empty0) m_mode = (enable && !flush) ? 1 : 0;
            endcase
            if (pipe.size() > 0 && pipe[0].pos == 2 && out_ready) void'(pipe.pop_front());
            if (pipe.size() > 0 && pipe[0].pos == 1) begin
`ifdef GPA_DROP_GATED_EN
                if (!pipe[0].gate) begin
                    void'(pipe.pop_front());
                    if (m_drops < 65535) m_drops++;
                end else begin
                    pipe[0].pos = 2;
                end
`else
                pipe[0].pos = 2;
`endif
            end
            if (g) begin
                t.id   = w;
                t.gate = req_gate[w];
                t.data = req_data[w*DW +: DW] & {DW{req_gate[w]}};
                t.pos  = 1;
                pipe.push_back(t);
`ifdef GPA_DROP_GATED_EN
                if (t.gate) sb.push_back(t);
`else
                sb.push_back(t);
`endif
                m_ptr = (w + 1) % NREQ;
            end
        end
    end

    // Monitor: per-cycle model comparison plus in-order scoreboard on handshakes.
    always @(negedge clk) begin
        bit   has2;
        txn_t t;
        if (mon_on) begin
            check("gnt", gnt, exp_gnt());
            check("busy", busy, m_mode != 0);
            has2 = (pipe.size() > 0) && (pipe[0].pos == 2);
            check("out_valid", out_valid, has2);
            if (has2) begin
                check("out_data", out_data, pipe[0].data);
                check("out_id", out_id, pipe[0].id);
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got id %0d data %0h, expected nothing", out_id, out_data);
                end else begin
                    t = sb.pop_front();
                    check("sb_data", out_data, t.data);
                    check("sb_id", out_id, t.id);
                end
            end
`ifdef GPA_DROP_GATED_EN
            check("drop_cnt", drop_cnt, m_drops);
`endif
        end
    end

    task automatic send(input int idx, input logic [DW-1:0] d, input bit g);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        req_data[idx*DW +: DW] = d;
        req_gate[idx] = g;
        req = NREQ'(1) << idx;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt[idx]) got = 1'b1;
        end
        check("send_granted", got, 1);
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic expect_out(input logic [DW-1:0] d, input int id);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("exp_seen", seen, 1);
        check("exp_data", out_data, d);
        check("exp_id", out_id, id);
    endtask

    initial begin
        logic [NREQ-1:0] seq [5];
        int              grants;
        bit              got;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with requests pending and enable high
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_id, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Round-robin fairness with all requesters active
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) check("run_busy", busy, 1);
            if (k < 5) check("rr_gnt", gnt, seq[k]);
            if (k >= 2) begin
                check("rr_valid", out_valid, 1);
                check("rr_id", out_id, (k - 2) % NREQ);
            end
        end
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);

        // Gating on requester 2
        send(2, 8'hA5, 1'b1);
        expect_out(8'hA5, 2);
        repeat (3) @(posedge clk);
        send(2, 8'hA5, 1'b0);
`ifdef GPA_DROP_GATED_EN
        repeat (6) @(negedge clk);
        check("drop_one", drop_cnt, 1);
`else
        expect_out(8'h00, 2);
`endif
        repeat (3) @(posedge clk);

        // Backpressure: two grants then stall with stable output
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_gate  = '1;
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        grants = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (gnt[0]) grants++;
            if (k == 3 || k == 5) begin
                check("bp_data", out_data, 8'h5A);
                check("bp_id", out_id, 0);
            end
        end
        check("bp_grants", grants, 2);
        @(posedge clk); #1;
        req = '0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Flush with two transactions in flight
        #1 req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_gnt", gnt, 0);
        @(posedge clk); #1 flush = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        check("flush_rerun", got, 1);
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req       = NREQ'($urandom);
            req_gate  = NREQ'($urandom);
            req_data  = (NREQ*DW)'($urandom);
            out_ready = ($urandom_range(9) < 7);
            enable    = ($urandom_range(19) != 0);
            flush     = ($urandom_range(29) == 0);
        end

        // Reset while the pipeline is full
        @(posedge clk); #1;
        enable = 1'b1;
        flush = 1'b0;
        req = 4'b1111;
        req_gate = '1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("mrst_ptr", gnt, 4'b0001);
        repeat (6) @(posedge clk);

        // Drain everything and confirm nothing is left owed
        #1 req = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gated_pipe_rr_arbiter.md
Name: gated_pipe_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one two-stage gated register pipeline among NREQ requesters.
- Stage 1 captures the winning requester's data. Stage 2 captures stage-1 data ANDed with a per-transaction gate bit.
- A run/drain state machine controls when grants are issued. A valid/ready output handshake gives backpressure into both stages.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per transaction.
- IDW, 2, width of requester index; must equal clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  permits grants when high
- flush  input  1  one-cycle pulse: stop granting and drain the pipeline
- req  input  NREQ  per-requester request, level, held until granted
- req_data  input  NREQ*DW  requester i occupies bits [i*DW +: DW]
- req_gate  input  NREQ  per-requester gate bit, ANDed onto data in stage 2
- gnt  output  NREQ  one-hot grant, combinational; transfer happens in the cycle req[i]&gnt[i]
- out_valid  output  1  stage-2 holds a transaction
- out_data  output  DW  stage-2 data (gated)
- out_id  output  IDW  index of the originating requester
- out_ready  input  1  consumer accepts when out_valid&out_ready
- busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (rst=1 at posedge) clears state to IDLE, ptr=0, v1=v2=0 and all data/id/gate regs to 0.
  - Result: out_valid=0, out_data=0, out_id=0, busy=0.
  - gnt=0 while rst=1.
  - Reset mid-operation discards all in-flight transactions.
- Advance conditions:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
- Grant rule:
  - Grants are issued only when state==RUN, adv1=1 and |req.
  - Winner = first set req scanning ptr, ptr+1, … with wrap mod NREQ; gnt is one-hot to the winner, otherwise 0.
  - On grant, ptr <= (winner+1) mod NREQ; ptr is otherwise unchanged.
- Stage 1:
  - On grant: v1<=1, d1<=req_data[winner], g1<=req_gate[winner], id1<=winner.
  - Else if adv2: v1<=0.
  - Else: hold.
- Stage 2:
  - If adv2: v2<=v1, out_data<=d1 & {DW{g1}}, out_id<=id1.
  - Else: hold; out_data and out_id stay stable while out_valid&!out_ready.
- Latency: transaction granted at cycle T appears with out_valid at T+2 when out_ready stays high. Throughput is 1 per cycle.
- Stall behaviour: with out_ready=0 the pipeline fills to 2 entries, after which adv1=0 and gnt=0. No transaction is ever lost or duplicated.
- FSM transitions (priority top-down within each state):
  - IDLE:
    - enable=1 and flush=0 -> RUN
  - RUN:
    - flush=1 or enable=0 -> DRAIN; no grant in the transition cycle
    - else stay
  - DRAIN: no grants.
    - When v1=0 and v2=0 -> IDLE, or -> RUN if enable=1 and flush=0 in that cycle
- busy = (state!=IDLE).
- Simultaneous events:
  - flush has priority over enable.
  - req changes while ungranted are allowed; arbitration uses current-cycle req.
  - out_ready and a new grant in the same cycle both advance.

Optional Feature:
- Macro: GPA_DROP_GATED_EN.
- Defined:
  - A transaction with g1=0 moving into stage 2 sets v2<=0 (dropped) instead of presenting zero data.
  - Adds output drop_cnt[15:0], reset 0, incremented per dropped transaction, saturating at 16'hFFFF.
  - Dropped transactions still consume their grant and advance ptr.
- Undefined:
  - Gated transactions are delivered with out_data=0 and the correct out_id.
  - No drop_cnt port.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, req=4'b1111, enable=1 -> gnt=0, out_valid=0, out_data=0, busy=0. After rst deasserts: busy=1 the next cycle and gnt=4'b0001 in the first RUN cycle.
- Round-robin fairness: enable=1, req=4'b1111 held, out_ready=1.
  - Required gnt sequence: 0001,0010,0100,1000,0001.
  - out_id sequence 0,1,2,3,0 starting 2 cycles after the first grant.
- Gating: requester 2 data=8'hA5.
  - gate=1 -> out_data=8'hA5, out_id=2.
  - gate=0 -> out_data=8'h00 (macro off) or no out_valid with drop_cnt=1 (macro on).
- Backpressure: stream from req[0], out_ready=0 for 5 cycles.
  - Exactly 2 grants, then gnt=0; out_data stable.
  - On out_ready=1 the held values come out in order, with no loss.
- Flush/drain: 2 transactions in flight, pulse flush -> gnt=0 immediately, both transactions are delivered, busy stays 1 until v1=v2=0. Then with enable=1 the FSM returns to RUN.
- Mid-flight reset: pipeline full, rst=1 for 1 cycle -> out_valid=0 next cycle, ptr=0, and the in-flight data never appears.
